psum_drain: RTL and testbench

Read-side controller for the corelet output FIFO. After a `start` pulse it pops a programmed number of partial-sum rows from the OFIFO and writes each row into the psum SRAM at consecutive addresses. It can optionally accumulate each row with the word already stored there, which supports multi-tile kernel accumulation. It sits between the corelet's OFIFO read port and the psum memory, in place of the testbench-driven `ofifo_rd` / `pmem` sequencing.

---
 rtl/psum_drain.sv | 134 +++++++++++++
 tb/tb_psum_drain.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain.sv
// rtl/psum_drain.sv - OFIFO-to-psum-SRAM drain controller with optional read-accumulate-write.
// Define PSUM_DRAIN_SAT_EN to saturate the per-lane accumulate instead of wrapping.
module psum_drain #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int addr_w  = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_w-1:0]      base_addr,
  input  logic [addr_w-1:0]      num_rows,
  input  logic                   acc,
  input  logic                   ofifo_o_valid,
  input  logic [col*psum_bw-1:0] ofifo_out,
  output logic                   ofifo_rd,
  output logic                   pmem_cen,
  output logic                   pmem_wen,
  output logic [addr_w-1:0]      pmem_a,
  output logic [col*psum_bw-1:0] pmem_d,
  input  logic [col*psum_bw-1:0] pmem_q,
  output logic                   busy,
  output logic                   done
);

  localparam int row_w = col * psum_bw;

  typedef enum logic [2:0] {IDLE, POP, ADD, WRITE, DONE} state_t;

  state_t             state, state_nxt;
  logic [addr_w-1:0]  addr, remaining, pmem_a_q;
  logic               acc_q;
  logic [row_w-1:0]   data, pmem_d_q, sum_row;
  logic [psum_bw-1:0] lane_a, lane_b, lane_res;
`ifdef PSUM_DRAIN_SAT_EN
  logic [psum_bw:0]   lane_sum;
`endif

  // Lane-wise signed add of the held row and the SRAM word; lanes never carry into each other.
  always_comb begin
    sum_row  = '0;
    lane_a   = '0;
    lane_b   = '0;
    lane_res = '0;
`ifdef PSUM_DRAIN_SAT_EN
    lane_sum = '0;
`endif
    for (int i = 0; i < col; i++) begin
      lane_a = data[i*psum_bw +: psum_bw];
      lane_b = pmem_q[i*psum_bw +: psum_bw];
`ifdef PSUM_DRAIN_SAT_EN
      lane_sum = {lane_a[psum_bw-1], lane_a} + {lane_b[psum_bw-1], lane_b};
      if (lane_sum[psum_bw] != lane_sum[psum_bw-1])
        lane_res = lane_sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      else
        lane_res = lane_sum[psum_bw-1:0];
`else
      lane_res = lane_a + lane_b;
`endif
      sum_row[i*psum_bw +: psum_bw] = lane_res;
    end
  end

  always_comb begin
    state_nxt = state;
    ofifo_rd  = 1'b0;
    pmem_cen  = 1'b1;
    pmem_wen  = 1'b1;
    pmem_a    = pmem_a_q;
    pmem_d    = pmem_d_q;
    case (state)
      IDLE: if (start) state_nxt = (num_rows == '0) ? DONE : POP;
      POP: begin
        if (ofifo_o_valid) begin
          ofifo_rd = 1'b1;
          if (acc_q) begin
            pmem_cen  = 1'b0;
            pmem_a    = addr;
            state_nxt = ADD;
          end else begin
            state_nxt = WRITE;
          end
        end
      end
      ADD: state_nxt = WRITE;
      WRITE: begin
        pmem_cen  = 1'b0;
        pmem_wen  = 1'b0;
        pmem_a    = addr;
        pmem_d    = data;
        state_nxt = (remaining == addr_w'(1)) ? DONE : POP;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // pmem_a/pmem_d hold the last driven value between accesses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      acc_q     <= 1'b0;
      data      <= '0;
      pmem_a_q  <= '0;
      pmem_d_q  <= '0;
    end else begin
      state    <= state_nxt;
      pmem_a_q <= pmem_a;
      pmem_d_q <= pmem_d;
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= num_rows;
            acc_q     <= acc;
          end
        end
        POP:   if (ofifo_o_valid) data <= ofifo_out;
        ADD:   data <= sum_row;
        WRITE: begin
          addr      <= addr + 1'b1;
          remaining <= remaining - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// tb/tb_psum_drain.sv - scoreboard bench for psum_drain with behavioural OFIFO and psum SRAM.
module tb_psum_drain;

  localparam int PB  = 16;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam int RW  = PB * COL;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_rows = '0;
  logic          acc = 1'b0;
  logic          ofifo_o_valid = 1'b0;
  logic [RW-1:0] ofifo_out = '0;
  logic          ofifo_rd;
  logic          pmem_cen, pmem_wen;
  logic [AW-1:0] pmem_a;
  logic [RW-1:0] pmem_d;
  logic [RW-1:0] pmem_q = '0;
  logic          busy, done;

  always #5 clk = ~clk;

  psum_drain #(.psum_bw(PB), .col(COL), .addr_w(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .acc(acc), .ofifo_o_valid(ofifo_o_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
    .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_a(pmem_a), .pmem_d(pmem_d),
    .pmem_q(pmem_q), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] a;
    logic [RW-1:0] d;
  } ev_t;

  logic [RW-1:0] mem [0:(1<<AW)-1];
  logic [RW-1:0] fifo_q [$];
  ev_t           exp_q [$];
  ev_t           mon_e;
  logic          stall = 1'b0;
  int            checks = 0, errors = 0;
  int            cyc = 0, last_rd_cyc = 0, last_wr_cyc = 0, stall_acc = 0;
  int            dc;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SRAM with one-cycle read latency, and OFIFO pop
  always @(posedge clk) begin
    cyc++;
    if (!pmem_cen && !pmem_wen) mem[pmem_a] <= pmem_d;
    if (!pmem_cen && pmem_wen) pmem_q <= mem[pmem_a];
    if (ofifo_rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
  end

  always @(negedge clk) begin
    #1;
    ofifo_o_valid = !stall && (fifo_q.size() != 0);
    ofifo_out     = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  end

  // monitor: every SRAM access is matched against the expected-event queue
  always @(negedge clk) begin
    #2;
    if (reset) begin
      checks++;
      if (ofifo_rd && !ofifo_o_valid) begin
        errors++;
        $display("FAIL rd_without_valid: ofifo_rd=1 while ofifo_o_valid=0");
      end
      if (!pmem_cen) begin
        if (stall) stall_acc++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: wen=%0b a=%0h, expected no access", pmem_wen, pmem_a);
        end else begin
          mon_e = exp_q.pop_front();
          chk("access_is_write", RW'(!pmem_wen), RW'(mon_e.wr));
          chk("access_addr", RW'(pmem_a), RW'(mon_e.a));
          if (mon_e.wr) chk("write_data", pmem_d, mon_e.d);
        end
        if (!pmem_wen) last_wr_cyc = cyc;
        else           last_rd_cyc = cyc;
      end
    end
  end

  function automatic logic [RW-1:0] row_all(input logic [PB-1:0] v);
    return {COL{v}};
  endfunction

  function automatic logic [RW-1:0] row_idx(input int r);
    logic [RW-1:0] x;
    x = '0;
    for (int j = 0; j < COL; j++) x[j*PB +: PB] = PB'(r * 256 + j + 1);
    return x;
  endfunction

  function automatic logic [RW-1:0] row3(input logic [PB-1:0] l0, input logic [PB-1:0] l1,
                                         input logic [PB-1:0] rest);
    logic [RW-1:0] x;
    x = row_all(rest);
    x[PB-1:0]    = l0;
    x[2*PB-1:PB] = l1;
    return x;
  endfunction

  task automatic exp_wr(input logic [AW-1:0] a, input logic [RW-1:0] d);
    exp_q.push_back('{wr: 1'b1, a: a, d: d});
  endtask

  task automatic exp_rd(input logic [AW-1:0] a);
    exp_q.push_back('{wr: 1'b0, a: a, d: '0});
  endtask

  // start a command and return the cycle (relative to the start cycle) at which done is seen
  task automatic run_cmd(input logic [AW-1:0] b, input logic [AW-1:0] n, input logic a,
                         input int stall_at, input int stall_len, input int glitch_at,
                         output int done_cyc);
    @(negedge clk);
    start = 1'b1; base_addr = b; num_rows = n; acc = a;
    done_cyc = -1;
    for (int k = 1; k <= 200 && done_cyc < 0; k++) begin
      @(negedge clk);
      start = 1'b0; base_addr = '0; num_rows = '0; acc = 1'b0;
      if (k == glitch_at) begin
        start = 1'b1; base_addr = 11'h555; num_rows = 11'd7; acc = 1'b1;
      end
      if (k == stall_at) stall = 1'b1;
      if (k == stall_at + stall_len) stall = 1'b0;
      #2;
      if (done) done_cyc = k;
    end
    if (done_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within 200 cycles");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #2;
    chk("rst_ofifo_rd", RW'(ofifo_rd), RW'(0));
    chk("rst_pmem_cen", RW'(pmem_cen), RW'(1));
    chk("rst_pmem_wen", RW'(pmem_wen), RW'(1));
    chk("rst_pmem_a", RW'(pmem_a), RW'(0));
    chk("rst_pmem_d", pmem_d, '0);
    chk("rst_busy", RW'(busy), RW'(0));
    chk("rst_done", RW'(done), RW'(0));
    @(negedge clk);
    reset = 1'b1;

    // non-acc drain of 4 rows, with a start pulse while busy and one coinciding with done
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(row_idx(i));
      exp_wr(AW'(16 + i), row_idx(i));
    end
    run_cmd(11'h010, 11'd4, 1'b0, -1, 0, 3, dc);
    chk("nonacc_done_cycle", RW'(dc), RW'(9));
    start = 1'b1; base_addr = 11'h600; num_rows = 11'd1;
    @(negedge clk);
    start = 1'b0; base_addr = '0; num_rows = '0;
    #2;
    chk("start_at_done_ignored_busy", RW'(busy), RW'(0));
    chk("nonacc_fifo_drained", RW'(fifo_q.size()), RW'(0));

    // accumulate one row: 5 + (-3) = 2 per lane
    mem[11'h020] = row_all(16'h0005);
    fifo_q.push_back(row_all(16'hFFFD));
    exp_rd(11'h020);
    exp_wr(11'h020, row_all(16'h0002));
    run_cmd(11'h020, 11'd1, 1'b1, -1, 0, -1, dc);
    chk("acc_done_cycle", RW'(dc), RW'(4));
    chk("acc_read_to_write", RW'(last_wr_cyc - last_rd_cyc), RW'(2));
    chk("acc_mem_result", mem[11'h020], row_all(16'h0002));

    // 5-cycle OFIFO stall in the middle of a 4-row drain
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(row_idx(i + 4));
      exp_wr(AW'(256 + i), row_idx(i + 4));
    end
    stall_acc = 0;
    run_cmd(11'h100, 11'd4, 1'b0, 3, 5, -1, dc);
    chk("stall_done_cycle", RW'(dc), RW'(14));
    chk("stall_no_access", RW'(stall_acc), RW'(0));

    // address wrap
    fifo_q.push_back(row_idx(8));
    fifo_q.push_back(row_idx(9));
    exp_wr(11'h7FF, row_idx(8));
    exp_wr(11'h000, row_idx(9));
    run_cmd(11'h7FF, 11'd2, 1'b0, -1, 0, -1, dc);
    chk("wrap_done_cycle", RW'(dc), RW'(5));

    // zero rows: done next cycle, row left in the FIFO
    fifo_q.push_back(row_idx(10));
    run_cmd(11'h050, 11'd0, 1'b0, -1, 0, -1, dc);
    chk("zero_done_cycle", RW'(dc), RW'(1));
    chk("zero_no_pop", RW'(fifo_q.size()), RW'(1));
    fifo_q.delete();

    // lane overflow
    mem[11'h060] = row3(16'h7FF0, 16'h8000, 16'h0001);
    fifo_q.push_back(row3(16'h0020, 16'hFFFF, 16'h0002));
    exp_rd(11'h060);
`ifdef PSUM_DRAIN_SAT_EN
    exp_wr(11'h060, row3(16'h7FFF, 16'h8000, 16'h0003));
`else
    exp_wr(11'h060, row3(16'h8010, 16'h7FFF, 16'h0003));
`endif
    run_cmd(11'h060, 11'd1, 1'b1, -1, 0, -1, dc);
    chk("ovf_done_cycle", RW'(dc), RW'(4));

    // reset during ADD abandons the command
    mem[11'h070] = row_all(16'h0001);
    for (int i = 0; i < 3; i++) fifo_q.push_back(row_idx(11 + i));
    exp_rd(11'h070);
    @(negedge clk);
    start = 1'b1; base_addr = 11'h070; num_rows = 11'd3; acc = 1'b1;
    @(negedge clk);
    start = 1'b0; base_addr = '0; num_rows = '0; acc = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", RW'(busy), RW'(0));
    chk("midrst_cen", RW'(pmem_cen), RW'(1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      chk("midrst_no_write", RW'({pmem_cen, pmem_wen}), RW'(2'b11));
    end
    reset = 1'b1;
    fifo_q.delete();
    chk("midrst_scoreboard_empty", RW'(exp_q.size()), RW'(0));

    fifo_q.push_back(row_idx(20));
    fifo_q.push_back(row_idx(21));
    exp_wr(11'h080, row_idx(20));
    exp_wr(11'h081, row_idx(21));
    run_cmd(11'h080, 11'd2, 1'b0, -1, 0, -1, dc);
    chk("after_rst_done_cycle", RW'(dc), RW'(5));

    @(negedge clk);
    #3;
    chk("final_scoreboard_empty", RW'(exp_q.size()), RW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
